branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter BHT_DEPTH, default 64, number of 2-bit counters; power of 2, minimum 4.
REQ-002 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; power of 2, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 f_pc  input  32  fetch PC used for prediction lookup.
REQ-006 f_pred_taken  output  1  combinational prediction, equal to the MSB of BHT[f_pc[log2(BHT_DEPTH)+1:2]].
REQ-007 f_ras_target  output  32  combinational top-of-stack return address.
REQ-008 f_ras_valid  output  1  high when the return-address stack is non-empty.
REQ-009 r_valid  input  1  resolve request this cycle.
REQ-010 r_instr  input  32  instruction being resolved; the opcode is r_instr[31:26].
REQ-011 r_pc  input  32  PC of the instruction being resolved.
REQ-012 r_reg_read, r_immediate  input  32 each  register operand and sign-extended offset.
REQ-013 r_N, r_Z  input  1 each  condition flags.
REQ-014 r_pred_taken  input  1  prediction carried down the pipe from fetch.
REQ-015 o_valid, o_take_branch, o_mispredict  output  1 each  registered resolve results.
REQ-016 o_target  output  32  registered branch/jump target.

Function
REQ-017 Opcodes: BEQZ 001100 takes on Z; BNEZ 001101 on ~Z; BLTZ 001110 on N; BGEZ 001111 on ~N|Z.
REQ-018 Jumps J 000100, JR 000101, JAL 000110 and JALR 000111 are always taken.
REQ-019 Any other opcode is a non-branch: take=0, mispredict=0, no BHT or RAS update.
REQ-020 Target = (PC+4) + r_immediate for BEQZ/BNEZ/BLTZ/BGEZ/J/JAL, and r_reg_read + r_immediate for JR/JALR.
REQ-021 Target is computed as a 32-bit add, modulo 2^32, carry discarded.
REQ-022 Resolve latency is 1 cycle: the o_* outputs reflect the r_* inputs sampled at the previous edge.
REQ-023 o_valid tracks r_valid with that 1-cycle delay; when o_valid=0, all other o_* outputs are 0.
REQ-024 o_mispredict = o_take_branch XOR r_pred_taken (sampled value), for branch and jump opcodes only.
REQ-025 BHT update on r_valid with a conditional-branch opcode, at index r_pc[log2(BHT_DEPTH)+1:2]: increment if taken, decrement if not.
REQ-026 BHT counters saturate at 2'b11 and 2'b00; jumps never update the BHT.
REQ-027 A same-cycle fetch read and resolve write to the same index returns the old value; the new value is visible next cycle.

Reset
REQ-028 rst_n low: every BHT counter = 2'b01 (weakly not-taken); RAS empty with pointer 0; all o_* outputs = 0.
REQ-029 Reset asserted mid-operation discards any in-flight resolve; no output pulse after release.
REQ-030 The first valid output follows the first r_valid sampled after rst_n deasserts.

Configuration
REQ-031 The RAS_EN macro compiles in the return-address stack.
REQ-032 With RAS_EN, JAL/JALR push r_pc+4.
REQ-033 With RAS_EN, JR pops.
REQ-034 With RAS_EN, a push when full overwrites the oldest entry (circular) and the count stays at RAS_DEPTH.
REQ-035 With RAS_EN, a pop when empty is ignored and f_ras_valid stays 0.
REQ-036 Without RAS_EN, f_ras_target = 0 and f_ras_valid = 0 constantly, and no stack storage exists.

Verification
REQ-037 Reset, then BEQZ at r_pc=0x100, Z=1, imm=0x20, r_pred_taken=0 -> next cycle o_take_branch=1, o_target=0x124, o_mispredict=1.
REQ-038 Resolve taken BNEZ at pc 0x40 three times -> f_pred_taken for f_pc=0x40 goes 0, then 1, then 1; a fourth taken update stays at 2'b11.
REQ-039 JR with r_reg_read=0xFFFFFFF0, imm=0x20 -> o_target=0x00000010 (wrap-around), BHT unchanged.
REQ-040 RAS_EN: five JALs at pcs 0x0, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH=4, then four JRs -> f_ras_target = 0x44, 0x34, 0x24, 0x14; then f_ras_valid=0.
REQ-041 Non-branch opcode 000000 with r_valid=1 and r_pred_taken=1 -> o_valid=1, o_take_branch=0, o_mispredict=0.
REQ-042 Assert rst_n low on the same edge as a valid BGEZ -> outputs 0 next cycle; counter at that index reads 2'b01.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Fetch-side branch prediction plus resolve-side branch/jump evaluation.
//   A table of BHT_DEPTH 2-bit saturating counters, indexed by PC word
//   address, supplies the fetch prediction. The resolve stage decodes the
//   opcode, evaluates the condition flags, computes the target and registers
//   the result one cycle later.
//
//   Optional feature (compile-time macro RAS_EN): a circular return-address
//   stack of RAS_DEPTH entries. JAL/JALR push pc+4 and JR pops. When RAS_EN
//   is undefined, no stack storage exists and the RAS outputs are constant 0.
//
// Parameters
//   BHT_DEPTH  number of 2-bit counters (power of 2, >= 4)
//   RAS_DEPTH  return-address-stack entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   f_pc            fetch PC for prediction lookup
//   f_pred_taken    combinational prediction (counter MSB)
//   f_ras_target    top-of-stack return address (0 when empty)
//   f_ras_valid     stack non-empty
//   r_valid         resolve request
//   r_instr         instruction being resolved (opcode in [31:26])
//   r_pc            PC of the resolved instruction
//   r_reg_read      register operand for JR/JALR
//   r_immediate     sign-extended offset
//   r_N, r_Z        condition flags
//   r_pred_taken    prediction made at fetch for this instruction
//   o_valid, o_take_branch, o_mispredict, o_target  registered results

module branch_predict_unit #(
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] f_ras_target,
  output logic        f_ras_valid,
  input  logic        r_valid,
  input  logic [31:0] r_instr,
  input  logic [31:0] r_pc,
  input  logic [31:0] r_reg_read,
  input  logic [31:0] r_immediate,
  input  logic        r_N,
  input  logic        r_Z,
  input  logic        r_pred_taken,
  output logic        o_valid,
  output logic        o_take_branch,
  output logic        o_mispredict,
  output logic [31:0] o_target
);

  localparam int unsigned IDX_W  = $clog2(BHT_DEPTH);
  localparam int unsigned RAS_AW = $clog2(RAS_DEPTH);

  typedef enum logic [3:0] {
    K_NONE,
    K_BEQZ,
    K_BNEZ,
    K_BLTZ,
    K_BGEZ,
    K_J,
    K_JR,
    K_JAL,
    K_JALR
  } op_kind_e;

  op_kind_e          kind;
  logic              is_cond;
  logic              is_jump;
  logic              take;
  logic [31:0]       target;
  logic [31:0]       pc_plus4;

  logic [1:0]        bht [BHT_DEPTH];
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        cnt_cur;
  logic [1:0]        cnt_next;

  logic              unused_bits;

  assign unused_bits = ^{r_instr[25:0], f_pc[31:IDX_W+2], f_pc[1:0]};

  assign pc_plus4 = r_pc + 32'd4;
  assign f_idx    = f_pc[IDX_W+1:2];
  assign r_idx    = r_pc[IDX_W+1:2];

  // ---------------------------------------------------------------- decode
  always_comb begin
    kind = K_NONE;
    case (r_instr[31:26])
      6'b001100: kind = K_BEQZ;
      6'b001101: kind = K_BNEZ;
      6'b001110: kind = K_BLTZ;
      6'b001111: kind = K_BGEZ;
      6'b000100: kind = K_J;
      6'b000101: kind = K_JR;
      6'b000110: kind = K_JAL;
      6'b000111: kind = K_JALR;
      default:   kind = K_NONE;
    endcase
  end

  // -------------------------------------------------- condition and target
  always_comb begin
    is_cond = 1'b0;
    is_jump = 1'b0;
    take    = 1'b0;
    target  = '0;
    case (kind)
      K_BEQZ: begin
        is_cond = 1'b1;
        take    = r_Z;
        target  = pc_plus4 + r_immediate;
      end
      K_BNEZ: begin
        is_cond = 1'b1;
        take    = ~r_Z;
        target  = pc_plus4 + r_immediate;
      end
      K_BLTZ: begin
        is_cond = 1'b1;
        take    = r_N;
        target  = pc_plus4 + r_immediate;
      end
      K_BGEZ: begin
        is_cond = 1'b1;
        take    = ~r_N | r_Z;
        target  = pc_plus4 + r_immediate;
      end
      K_J, K_JAL: begin
        is_jump = 1'b1;
        take    = 1'b1;
        target  = pc_plus4 + r_immediate;
      end
      K_JR, K_JALR: begin
        is_jump = 1'b1;
        take    = 1'b1;
        target  = r_reg_read + r_immediate;
      end
      default: begin
        is_cond = 1'b0;
        is_jump = 1'b0;
        take    = 1'b0;
        target  = '0;
      end
    endcase
  end

  // ------------------------------------------------------ resolve outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid       <= 1'b0;
      o_take_branch <= 1'b0;
      o_mispredict  <= 1'b0;
      o_target      <= '0;
    end else begin
      o_valid <= r_valid;
      if (r_valid) begin
        o_take_branch <= take;
        o_mispredict  <= (is_cond | is_jump) & (take ^ r_pred_taken);
        o_target      <= target;
      end else begin
        o_take_branch <= 1'b0;
        o_mispredict  <= 1'b0;
        o_target      <= '0;
      end
    end
  end

  // ------------------------------------------------------- history table
  assign cnt_cur = bht[r_idx];

  always_comb begin
    cnt_next = cnt_cur;
    if (take && cnt_cur != 2'b11) begin
      cnt_next = cnt_cur + 2'b01;
    end else if (!take && cnt_cur != 2'b00) begin
      cnt_next = cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[IDX_W'(i)] <= 2'b01;
      end
    end else if (r_valid && is_cond) begin
      bht[r_idx] <= cnt_next;
    end
  end

  // Array read is combinational and the write lands on the edge, so a
  // same-cycle read of the index being updated sees the old counter.
  assign f_pred_taken = bht[f_idx][1];

  // ------------------------------------------------ return-address stack
`ifdef RAS_EN
  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW+1)'(RAS_DEPTH);

  logic [31:0]       ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_ptr;   // next slot to write; top is ras_ptr-1
  logic [RAS_AW:0]   ras_cnt;
  logic              ras_push;
  logic              ras_pop;

  assign ras_push = r_valid & ((kind == K_JAL) | (kind == K_JALR));
  assign ras_pop  = r_valid & (kind == K_JR);

  // Pushing when full keeps writing circularly over the oldest entry while
  // the count stays pinned, so the newest RAS_DEPTH entries survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[RAS_AW'(i)] <= '0;
      end
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= pc_plus4;
      ras_ptr          <= ras_ptr + RAS_AW'(1);
      if (ras_cnt != RAS_FULL) begin
        ras_cnt <= ras_cnt + (RAS_AW+1)'(1);
      end
    end else if (ras_pop && ras_cnt != '0) begin
      ras_ptr <= ras_ptr - RAS_AW'(1);
      ras_cnt <= ras_cnt - (RAS_AW+1)'(1);
    end
  end

  assign f_ras_valid  = (ras_cnt != '0);
  assign f_ras_target = f_ras_valid ? ras_mem[ras_ptr - RAS_AW'(1)] : '0;
`else
  logic [RAS_AW:0] unused_ras_cfg;

  assign unused_ras_cfg = '0;
  assign f_ras_valid    = 1'b0;
  assign f_ras_target   = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed
// by randomized resolves, all compared against a behavioural model made of
// an integer counter array and a queue-based return stack.

module tb_branch_predict_unit;

  localparam int unsigned BHT_DEPTH = 64;
  localparam int unsigned RAS_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_ras_target;
  logic        f_ras_valid;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_reg_read;
  logic [31:0] r_immediate;
  logic        r_N;
  logic        r_Z;
  logic        r_pred_taken;
  logic        o_valid;
  logic        o_take_branch;
  logic        o_mispredict;
  logic [31:0] o_target;

  branch_predict_unit #(
    .BHT_DEPTH(BHT_DEPTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .f_pc         (f_pc),
    .f_pred_taken (f_pred_taken),
    .f_ras_target (f_ras_target),
    .f_ras_valid  (f_ras_valid),
    .r_valid      (r_valid),
    .r_instr      (r_instr),
    .r_pc         (r_pc),
    .r_reg_read   (r_reg_read),
    .r_immediate  (r_immediate),
    .r_N          (r_N),
    .r_Z          (r_Z),
    .r_pred_taken (r_pred_taken),
    .o_valid      (o_valid),
    .o_take_branch(o_take_branch),
    .o_mispredict (o_mispredict),
    .o_target     (o_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert;
  int          n_fail;
  int          bht_m [BHT_DEPTH];
  logic [31:0] ras_m [$];

  localparam logic [5:0] OP_BEQZ = 6'b001100;
  localparam logic [5:0] OP_BNEZ = 6'b001101;
  localparam logic [5:0] OP_BLTZ = 6'b001110;
  localparam logic [5:0] OP_BGEZ = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JR   = 6'b000101;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_JALR = 6'b000111;

  logic [5:0] op_tab [8] = '{OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ,
                             OP_J, OP_JR, OP_JAL, OP_JALR};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_DEPTH);
  endfunction

  task automatic model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    ras_m.delete();
  endtask

  // Combinational fetch-side outputs against the model's current state.
  task automatic check_fetch();
    check("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, bht_m[idx_of(f_pc)] >= 2});
`ifdef RAS_EN
    check("f_ras_valid", {31'd0, f_ras_valid}, {31'd0, ras_m.size() > 0});
    if (ras_m.size() > 0) check("f_ras_target", f_ras_target, ras_m[$]);
`else
    check("f_ras_valid", {31'd0, f_ras_valid}, 32'd0);
    check("f_ras_target", f_ras_target, 32'd0);
`endif
  endtask

  // One resolve cycle: starts just after a rising edge, ends 1 time unit
  // after the following rising edge.
  task automatic resolve(input logic v, input logic [5:0] op,
                         input logic [31:0] pc, input logic [31:0] rr,
                         input logic [31:0] imm, input logic n, input logic z,
                         input logic pred, input logic [31:0] fpc);
    logic        br, cond, tk, mis;
    logic [31:0] tgt;
    logic [25:0] low;
    low          = 26'($urandom);
    r_valid      = v;
    r_instr      = {op, low};
    r_pc         = pc;
    r_reg_read   = rr;
    r_immediate  = imm;
    r_N          = n;
    r_Z          = z;
    r_pred_taken = pred;
    f_pc         = fpc;
    #1;
    check_fetch();

    br = 1'b0; cond = 1'b0; tk = 1'b0; tgt = 32'd0;
    case (op)
      OP_BEQZ: begin br = 1; cond = 1; tk = z;      tgt = pc + 32'd4 + imm; end
      OP_BNEZ: begin br = 1; cond = 1; tk = !z;     tgt = pc + 32'd4 + imm; end
      OP_BLTZ: begin br = 1; cond = 1; tk = n;      tgt = pc + 32'd4 + imm; end
      OP_BGEZ: begin br = 1; cond = 1; tk = !n || z; tgt = pc + 32'd4 + imm; end
      OP_J, OP_JAL:   begin br = 1; tk = 1; tgt = pc + 32'd4 + imm; end
      OP_JR, OP_JALR: begin br = 1; tk = 1; tgt = rr + imm; end
      default: ;
    endcase
    mis = br && (tk != pred);

    if (v) begin
      if (cond) begin
        if (tk) bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] < 3) ? bht_m[idx_of(pc)] + 1 : 3;
        else    bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] > 0) ? bht_m[idx_of(pc)] - 1 : 0;
      end
`ifdef RAS_EN
      if (op == OP_JAL || op == OP_JALR) begin
        ras_m.push_back(pc + 32'd4);
        if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
      end else if (op == OP_JR && ras_m.size() > 0) begin
        void'(ras_m.pop_back());
      end
`endif
    end

    @(posedge clk);
    #1;
    check("o_valid", {31'd0, o_valid}, {31'd0, v});
    if (v) begin
      check("o_take_branch", {31'd0, o_take_branch}, {31'd0, tk});
      check("o_mispredict", {31'd0, o_mispredict}, {31'd0, mis});
      if (br) check("o_target", o_target, tgt);
    end else begin
      check("o_take_branch_idle", {31'd0, o_take_branch}, 32'd0);
      check("o_mispredict_idle", {31'd0, o_mispredict}, 32'd0);
      check("o_target_idle", o_target, 32'd0);
    end
  endtask

  task automatic do_reset();
    r_valid = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_take", {31'd0, o_take_branch}, 32'd0);
    check("rst_o_mispredict", {31'd0, o_mispredict}, 32'd0);
    check("rst_o_target", o_target, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ras_exp [4];
    logic [31:0] rpc, fpc;
    logic [5:0]  op;
    int          sel;

    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0; r_valid = 1'b0; r_instr = '0; r_pc = '0; r_reg_read = '0;
    r_immediate = '0; r_N = 1'b0; r_Z = 1'b0; r_pred_taken = 1'b0; f_pc = '0;
    ras_exp = '{32'h44, 32'h34, 32'h24, 32'h14};

    do_reset();
    check_fetch();

    // BEQZ taken, predicted not-taken
    resolve(1, OP_BEQZ, 32'h100, 32'h0, 32'h20, 0, 1, 0, 32'h100);
    check("beqz_target_const", o_target, 32'h124);
    check("beqz_mispredict_const", {31'd0, o_mispredict}, 32'd1);

    // BNEZ taken four times at 0x40 with a concurrent fetch of 0x40, then
    // two not-taken updates to walk back down from saturation.
    repeat (4) resolve(1, OP_BNEZ, 32'h40, 32'h0, 32'h8, 0, 0, 0, 32'h40);
    resolve(1, OP_BNEZ, 32'h40, 32'h0, 32'h8, 0, 1, 1, 32'h40);
    resolve(1, OP_BNEZ, 32'h40, 32'h0, 32'h8, 0, 1, 1, 32'h40);
    resolve(0, OP_BNEZ, 32'h40, 32'h0, 32'h8, 0, 1, 1, 32'h40);
    check("bnez_after_walkdown", {31'd0, f_pred_taken}, 32'd0);

    // JR target wrap-around; must not touch the counter at its index
    resolve(1, OP_JR, 32'h200, 32'hFFFF_FFF0, 32'h20, 0, 0, 1, 32'h200);
    check("jr_wrap_const", o_target, 32'h0000_0010);
    resolve(0, 6'b0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h200);

    // Non-branch with a taken prediction
    resolve(1, 6'b000000, 32'h300, 32'h5, 32'h7, 1, 1, 1, 32'h300);
    check("nonbranch_mis_const", {31'd0, o_mispredict}, 32'd0);

    // Branch inputs with r_valid low
    resolve(0, OP_BEQZ, 32'h100, 32'h0, 32'h20, 0, 1, 0, 32'h100);

`ifdef RAS_EN
    do_reset();
    for (int i = 0; i < 5; i++)
      resolve(1, OP_JAL, 32'(i * 16), 32'h0, 32'h100, 0, 0, 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b0;
      #1;
      check("ras_seq", f_ras_target, ras_exp[i]);
      resolve(1, OP_JR, 32'h500, 32'h1000, 32'h0, 0, 0, 1, 32'h0);
    end
    check("ras_empty", {31'd0, f_ras_valid}, 32'd0);
    resolve(1, OP_JR, 32'h500, 32'h1000, 32'h0, 0, 0, 1, 32'h0);
    check("ras_pop_empty", {31'd0, f_ras_valid}, 32'd0);
`endif

    // Randomized resolves
    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       op = op_tab[sel];
      else if (sel == 8) op = 6'b000000;
      else               op = 6'($urandom);
      rpc = $urandom & 32'hFFFF_FF3C;
      fpc = ($urandom_range(0, 1) == 1) ? rpc : ($urandom & 32'hFFFF_FF3C);
      resolve(($urandom_range(0, 7) != 0), op, rpc, $urandom, $urandom,
              1'($urandom), 1'($urandom), 1'($urandom), fpc);
    end

    // Reset landing on the edge of a valid BGEZ
    r_valid = 1'b1; r_instr = {OP_BGEZ, 26'h0}; r_pc = 32'h40;
    r_N = 1'b0; r_Z = 1'b0; r_pred_taken = 1'b0; f_pc = 32'h40;
    #3 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_mid_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_mid_o_take", {31'd0, o_take_branch}, 32'd0);
    check("rst_mid_o_target", o_target, 32'd0);
    check("rst_mid_pred", {31'd0, f_pred_taken}, 32'd0);
    r_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_no_pulse", {31'd0, o_valid}, 32'd0);
    resolve(1, OP_BGEZ, 32'h40, 32'h0, 32'h4, 0, 0, 0, 32'h40);
    resolve(0, 6'b0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h40);
    check("rst_counter_weak", {31'd0, f_pred_taken}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
